// File: rtl/tt_um_pwm_duty_meter.sv
// PWM duty-cycle meter.
// Samples an asynchronous PWM input through a two-flop synchronizer, measures
// period and high time in clk cycles, then converts high/period to a duty code
// in 10 % steps (0..10) with a 4-iteration restoring divider.
// A missing rising edge for 2^CNT_W-1 cycles is reported as a stuck input.
`timescale 1ns/1ps

module tt_um_pwm_duty_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ui_pwm_in,
  output logic [CNT_W-1:0] uo_period_cnt,
  output logic [CNT_W-1:0] uo_high_cnt,
  output logic [3:0]       uo_duty,
  output logic             uo_valid,
  output logic             uo_stuck
);

  // Remainder needs room for high*10, which is below 16*2^CNT_W.
  localparam int REM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_ARMED      = 2'd1,
    ST_DIV        = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  // One restoring-division step: compare the remainder against the divisor
  // shifted by the current bit position. Returns {quotient_bit, new_remainder}.
  function automatic logic [REM_W:0] div_step(
    input logic [REM_W-1:0] rem,
    input logic [CNT_W-1:0] dvs,
    input logic [1:0]       sh
  );
    logic [REM_W-1:0] shifted;
    shifted = {4'b0000, dvs} << sh;
    if (rem >= shifted) begin
      div_step = {1'b1, rem - shifted};
    end else begin
      div_step = {1'b0, rem};
    end
  endfunction

  logic             sync1_r;
  logic             sync_r;
  logic             prev_r;
  logic             rise_s;
  logic [CNT_W-1:0] per_cnt_r;
  logic [CNT_W-1:0] hi_cnt_r;
  state_t           state_r;
  logic [CNT_W-1:0] divisor_r;
  logic [CNT_W-1:0] high_r;
  logic [REM_W-1:0] rem_r;
  logic [3:0]       quo_r;
  logic [1:0]       iter_r;
  logic [REM_W-1:0] dividend_s;
  logic [REM_W:0]   first_step_s;
  logic [REM_W:0]   iter_step_s;
  logic             timeout_s;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync_r  <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= ui_pwm_in;
      sync_r  <= sync1_r;
      prev_r  <= sync_r;
    end
  end

  assign rise_s = sync_r & ~prev_r;

  // Period and high-time counters: restart at 1 on every rising edge, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_r <= {CNT_W{1'b0}};
      hi_cnt_r  <= {CNT_W{1'b0}};
    end else if (rise_s) begin
      per_cnt_r <= CNT_ONE;
      hi_cnt_r  <= CNT_ONE;
    end else begin
      if (per_cnt_r != CNT_MAX) begin
        per_cnt_r <= per_cnt_r + CNT_ONE;
      end else begin
        per_cnt_r <= per_cnt_r;
      end
      if (sync_r && (hi_cnt_r != CNT_MAX)) begin
        hi_cnt_r <= hi_cnt_r + CNT_ONE;
      end else begin
        hi_cnt_r <= hi_cnt_r;
      end
    end
  end

  // Divider datapath: the first step runs straight off the live counters so
  // bit 3 is resolved on the same edge that latches the measurement.
  always_comb begin
    dividend_s   = ({4'b0000, hi_cnt_r} << 2'd3) + ({4'b0000, hi_cnt_r} << 2'd1);
    first_step_s = div_step(dividend_s, per_cnt_r, 2'd3);
    iter_step_s  = div_step(rem_r, divisor_r, iter_r);
    if (((state_r == ST_WAIT_FIRST) || (state_r == ST_ARMED)) &&
        (per_cnt_r == CNT_MAX) && !uo_stuck && !rise_s) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Measurement FSM: arms on the first edge, latches and divides on the next,
  // publishes results, and reports a stuck input once per stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAIT_FIRST;
      divisor_r     <= {CNT_W{1'b0}};
      high_r        <= {CNT_W{1'b0}};
      rem_r         <= {REM_W{1'b0}};
      quo_r         <= 4'd0;
      iter_r        <= 2'd0;
      uo_period_cnt <= {CNT_W{1'b0}};
      uo_high_cnt   <= {CNT_W{1'b0}};
      uo_duty       <= 4'd0;
      uo_valid      <= 1'b0;
      uo_stuck      <= 1'b0;
    end else begin
      uo_valid <= 1'b0;
      if (rise_s) begin
        uo_stuck <= 1'b0;
      end else begin
        uo_stuck <= uo_stuck;
      end

      case (state_r)
        ST_WAIT_FIRST: begin
          if (rise_s) begin
            state_r <= ST_ARMED;
          end else if (timeout_s) begin
            uo_stuck      <= 1'b1;
            uo_duty       <= sync_r ? 4'd10 : 4'd0;
            uo_high_cnt   <= {CNT_W{1'b0}};
            uo_period_cnt <= {CNT_W{1'b0}};
            uo_valid      <= 1'b1;
            state_r       <= ST_WAIT_FIRST;
          end else begin
            state_r <= ST_WAIT_FIRST;
          end
        end

        ST_ARMED: begin
          if (rise_s) begin
            divisor_r <= per_cnt_r;
            high_r    <= hi_cnt_r;
            rem_r     <= first_step_s[REM_W-1:0];
            quo_r     <= {first_step_s[REM_W], 3'b000};
            iter_r    <= 2'd2;
            state_r   <= ST_DIV;
          end else if (timeout_s) begin
            uo_stuck      <= 1'b1;
            uo_duty       <= sync_r ? 4'd10 : 4'd0;
            uo_high_cnt   <= {CNT_W{1'b0}};
            uo_period_cnt <= {CNT_W{1'b0}};
            uo_valid      <= 1'b1;
            state_r       <= ST_WAIT_FIRST;
          end else begin
            state_r <= ST_ARMED;
          end
        end

        // Edges arriving here still restart the counters, but the period
        // they close is dropped because no latch happens outside ARMED.
        ST_DIV: begin
          rem_r         <= iter_step_s[REM_W-1:0];
          quo_r[iter_r] <= iter_step_s[REM_W];
          if (iter_r == 2'd0) begin
            state_r <= ST_DONE;
          end else begin
            iter_r  <= iter_r - 2'd1;
            state_r <= ST_DIV;
          end
        end

        ST_DONE: begin
          uo_duty       <= quo_r;
          uo_high_cnt   <= high_r;
          uo_period_cnt <= divisor_r;
          uo_valid      <= 1'b1;
          state_r       <= ST_ARMED;
        end

        default: begin
          state_r <= ST_WAIT_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_pwm_duty_meter.sv
// Self-checking bench for tt_um_pwm_duty_meter: table-driven PWM patterns
// feed a stimulus-side model that queues expected results; every uo_valid
// pops and compares one entry. Corner cases are hand-written sequences.
`timescale 1ns/1ps

module tb_tt_um_pwm_duty_meter;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_sync = 1'b0;
  logic             pwm_async = 1'b0;
  logic             async_on = 1'b0;
  logic             pwm_in;
  logic [CNT_W-1:0] uo_period_cnt;
  logic [CNT_W-1:0] uo_high_cnt;
  logic [3:0]       uo_duty;
  logic             uo_valid;
  logic             uo_stuck;

  assign pwm_in = async_on ? pwm_async : pwm_sync;

  tt_um_pwm_duty_meter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_pwm_in    (pwm_in),
    .uo_period_cnt(uo_period_cnt),
    .uo_high_cnt  (uo_high_cnt),
    .uo_duty      (uo_duty),
    .uo_valid     (uo_valid),
    .uo_stuck     (uo_stuck)
  );

  always #5 clk = ~clk;

  // Free-running asynchronous PWM: 43 ns period, ~50 % duty.
  initial begin
    forever begin
      if (async_on) begin
        pwm_async = 1'b1;
        #22;
        pwm_async = 1'b0;
        #21;
      end else begin
        pwm_async = 1'b0;
        #5;
      end
    end
  end

  typedef struct {
    int period;
    int high;
    int duty;
    int stuck;
  } exp_t;

  typedef struct {
    int period;
    int high;
    int duty;
    int reps;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int n_valid = 0;
  int n_async = 0;
  bit sb_on = 1'b1;

  // stimulus-side model state
  int   t = 0;
  int   last_acc = 0;
  bit   armed = 1'b0;
  exp_t prev_e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Called once per cycle on the falling edge: consumes any result pulse.
  task automatic observe();
    exp_t e;
    bit   ok;
    if (uo_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      checks++;
      if (sb_on) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid at cycle %0d: got period=%0d high=%0d duty=%0d stuck=%0d, expected no result",
                   cyc, uo_period_cnt, uo_high_cnt, uo_duty, uo_stuck);
        end else begin
          e = sb.pop_front();
          if ((int'(uo_period_cnt) != e.period) || (int'(uo_high_cnt) != e.high) ||
              (int'(uo_duty) != e.duty) || (int'(uo_stuck) != e.stuck)) begin
            errors++;
            $display("FAIL result at cycle %0d: got period=%0d high=%0d duty=%0d stuck=%0d, expected period=%0d high=%0d duty=%0d stuck=%0d",
                     cyc, uo_period_cnt, uo_high_cnt, uo_duty, uo_stuck, e.period, e.high, e.duty, e.stuck);
          end
        end
      end else begin
        n_async++;
        ok = (uo_period_cnt >= 8'd4) && (uo_period_cnt <= 8'd5) &&
             (uo_high_cnt >= 8'd1) && (uo_high_cnt <= 8'd3) &&
             (uo_duty >= 4'd2) && (uo_duty <= 4'd7) && (uo_stuck == 1'b0);
        if (!ok) begin
          errors++;
          $display("FAIL async_range at cycle %0d: got period=%0d high=%0d duty=%0d stuck=%0d, expected period 4-5 high 1-3 duty 2-7 stuck 0",
                   cyc, uo_period_cnt, uo_high_cnt, uo_duty, uo_stuck);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  // A rising edge at stimulus cycle t: the first one only arms; later ones
  // close a period, which is reported only if at least 5 cycles have passed
  // since the last reported edge (otherwise the divider is still busy).
  task automatic rise_model();
    if (!armed) begin
      armed    = 1'b1;
      last_acc = t - 5;
    end else if ((t - last_acc) >= 5) begin
      sb.push_back(prev_e);
      last_acc = t;
    end
  endtask

  task automatic gen_period(input int p, input int h, input int d);
    rise_model();
    prev_e = '{p, h, d, 0};
    for (int i = 0; i < p; i++) begin
      pwm_sync = (i < h) ? 1'b1 : 1'b0;
      tick();
      t++;
    end
  endtask

  task automatic hold(input bit v, input int n);
    if (v) rise_model();
    sb.push_back('{0, 0, (v ? 10 : 0), 1});
    armed = 1'b0;
    for (int i = 0; i < n; i++) begin
      pwm_sync = v;
      tick();
      t++;
    end
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) begin
      pwm_sync = 1'b0;
      tick();
      t++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_period"}, int'(uo_period_cnt), 0);
    chk({tag, "_high"},   int'(uo_high_cnt), 0);
    chk({tag, "_duty"},   int'(uo_duty), 0);
    chk({tag, "_valid"},  int'(uo_valid), 0);
    chk({tag, "_stuck"},  int'(uo_stuck), 0);
  endtask

  initial begin
    int nv0;
    int c_r;
    int v1;

    // duty sweep with period 10, then a rounding case at period 20
    for (int h = 1; h <= 9; h++) begin
      vecs[h-1] = '{10, h, h, 2};
    end
    vecs[9] = '{20, 7, 3, 3};

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle_low(2);

    // start-up: first edge only arms, second produces a result 6 edges later
    nv0 = n_valid;
    gen_period(10, 3, 3);
    chk("first_edge_no_valid", n_valid, nv0);
    c_r = cyc + 1;
    gen_period(10, 3, 3);
    chk("startup_latency", last_valid_cyc - c_r, 6);
    v1 = last_valid_cyc;
    gen_period(10, 3, 3);
    chk("pulse_spacing", last_valid_cyc - v1, 10);

    // duty sweep
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        gen_period(vecs[i].period, vecs[i].high, vecs[i].duty);
      end
    end

    // stuck high after a valid measurement
    gen_period(10, 5, 5);
    hold(1'b1, 300);
    chk("stuck_high_flag", int'(uo_stuck), 1);
    chk("stuck_high_duty", int'(uo_duty), 10);
    chk("stuck_high_period", int'(uo_period_cnt), 0);
    idle_low(3);
    gen_period(10, 4, 4);
    chk("stuck_cleared_by_edge", int'(uo_stuck), 0);
    gen_period(10, 4, 4);
    gen_period(10, 4, 4);

    // stuck low
    hold(1'b0, 300);
    chk("stuck_low_flag", int'(uo_stuck), 1);
    chk("stuck_low_duty", int'(uo_duty), 0);
    chk("stuck_low_high", int'(uo_high_cnt), 0);
    gen_period(10, 6, 6);
    gen_period(10, 6, 6);
    gen_period(10, 6, 6);

    // short period: only alternate periods are reported
    for (int i = 0; i < 10; i++) begin
      gen_period(3, 1, 3);
    end
    gen_period(10, 3, 3);
    gen_period(10, 3, 3);

    // reset two cycles after a latch
    chk("queue_empty_before_reset", sb.size(), 0);
    pwm_sync = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_div_reset");
    sb.delete();
    armed = 1'b0;
    pwm_sync = 1'b0;
    repeat (3) tick();
    chk("reset_hold_valid", int'(uo_valid), 0);
    rst_n = 1'b1;
    nv0 = n_valid;
    gen_period(10, 3, 3);
    chk("after_reset_first_edge_no_valid", n_valid, nv0);
    gen_period(10, 3, 3);
    gen_period(10, 3, 3);
    idle_low(10);
    chk("queue_drained", sb.size(), 0);
    chk("result_count_min", (n_valid >= 30) ? 1 : 0, 1);

    // asynchronous PWM input: range checks only
    rst_n = 1'b0;
    sb_on = 1'b0;
    async_on = 1'b1;
    repeat (2) tick();
    @(negedge pwm_async);
    rst_n = 1'b1;
    for (int i = 0; (i < 400) && (n_async < 6); i++) begin
      tick();
    end
    chk("async_results_seen", (n_async >= 6) ? 1 : 0, 1);
    async_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_pwm_duty_meter.md
# tt_um_pwm_duty_meter

PWM duty-cycle meter: the receive-side counterpart of the PWM generator. It samples an asynchronous PWM waveform and measures its period and high time in clock cycles. A small iterative divider converts the measurement to a duty code in 10 % steps (0–10), matching the generator's duty granularity. Used in loopback self-test of the generator and as a standalone tachometer/duty input.

## Interface
Parameters:
- `CNT_W`, default 8: width of the period and high-time counters. The maximum measurable period is 2^CNT_W − 2 cycles.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ui_pwm_in`, input, 1: PWM waveform, asynchronous to `clk`.
- `uo_period_cnt`, output, CNT_W: last measured period, in clk cycles.
- `uo_high_cnt`, output, CNT_W: last measured high time, in clk cycles.
- `uo_duty`, output, 4: floor(10·high/period). Range 0–10.
- `uo_valid`, output, 1: one-cycle pulse when the outputs update.
- `uo_stuck`, output, 1: no rising edge seen for 2^CNT_W − 1 cycles.

## Operation
- **Synchronizer:** two flops, both reset to 0. `prev` holds the previous synchronized value. A rising edge is `sync & ~prev`.
- **Counters:** `per_cnt` and `hi_cnt`, both CNT_W wide.
  - On a rising edge, both load 1.
  - Otherwise `per_cnt` increments every cycle, saturating at 2^CNT_W − 1.
  - Otherwise `hi_cnt` increments when `sync` = 1, also saturating.
- **States:**
  - WAIT_FIRST (reset state): on a rising edge → ARMED. Counters restart; no result is produced.
  - ARMED: on a rising edge, latch `per_cnt` → divisor and `hi_cnt` → high, then → DIV. Counters restart.
  - DIV: runs 4 restoring-division iterations, one per cycle.
    - Dividend = high·10, width CNT_W+4.
    - At iteration i = 3..0, if remainder ≥ divisor<<i: subtract and set quotient bit i.
    - After iteration 0, register `uo_duty`, `uo_high_cnt` and `uo_period_cnt` together, pulse `uo_valid`, then → ARMED.
  - Rising edges during DIV restart the counters, but the period they close is discarded and no result is produced for it.
- **Timeout:** in ARMED or WAIT_FIRST, when `per_cnt` reaches 2^CNT_W − 1:
  - set `uo_stuck` = 1;
  - set `uo_duty` = 10 if `sync` = 1, else 0;
  - set `uo_high_cnt` = 0 and `uo_period_cnt` = 0;
  - pulse `uo_valid` once;
  - → WAIT_FIRST.
  - No further pulses occur while the input stays stuck; `per_cnt` holds at saturation.
- `uo_stuck` clears on the next rising edge.
- **Arithmetic:** high ≤ period always holds, so the quotient is ≤ 10 and 4 iterations suffice. Period ≥ 1 always, so there is no divide-by-zero.
- **Reset (any time, including mid-DIV):**
  - all state → WAIT_FIRST;
  - all outputs → 0;
  - the in-flight division is abandoned.

## Timing
- Latency from a raw rising edge to the result:
  - clk edge 0 first samples `ui_pwm_in` = 1;
  - edge-detect is valid after edge 1;
  - latch and iteration 3 occur at edge 2;
  - iterations 2, 1, 0 occur at edges 3–5;
  - outputs and `uo_valid` = 1 appear after edge 6, for one cycle.
- The minimum period that is reported every cycle is 5 clk cycles. Shorter periods are reported at most every other period.
- Counts are in synchronized-domain cycles, so they carry ±1-cycle quantization for asynchronous inputs.
- The timeout asserts `uo_stuck` and `uo_valid` on the cycle after `per_cnt` reaches saturation.
- Outputs hold their values between `uo_valid` pulses.

## Test plan
- **Start-up:** reset, then apply period 10 / high 3 (synchronous to clk). The first rising edge gives no `uo_valid`. After the second edge, expect `uo_valid` 6 edges later with period = 10, high = 3, duty = 3, then one pulse per 10 cycles.
- **Duty sweep:** step high time 1→9 in steps of 1 with period 10. Expect duty 1..9 with exact high counts. Then set period 20 / high 7: expect duty 3 (floor of 3.5).
- **Stuck input:** with CNT_W = 8, hold the input high after a valid measurement. Expect `uo_stuck` = 1, duty = 10, counts = 0 and exactly one `uo_valid`. Repeat with the input held low: expect duty = 0. The next two rising edges clear `uo_stuck` and then produce a fresh result.
- **Short period:** apply period 3 / high 1. Expect results only for alternate periods, each with period = 3, high = 1, duty = 3. Expect no X values and no spurious `uo_valid`.
- **Reset mid-DIV:** assert `rst_n` = 0 two cycles after a latch. Expect all outputs 0 immediately, with no `uo_valid`. After release, expect WAIT_FIRST behaviour again.
- **Asynchronous input:** drive a PWM with period 40 ns + 3 ns and duty 50 % against a 10 ns clk. Expect period within 4–5, high within 1–3, duty within 2–7, and no metastability X propagation in gate-level simulation.
